timer_input_conditioner: RTL and testbench
==========================================

// Module: timer_input_conditioner
// PURPOSE
//  Front end for the countdown timer: turns raw board keys/switch into clean, clk-synchronous
//  single-cycle command pulses (stc/inc/run) and generates the 1 Hz count tick and blink enable.
//  Sits directly upstream of the timer counter; all its outputs feed that block on the same clk.
// PARAMETERS
//  TICK_DIV        50_000_000  clk cycles per count tick (1 Hz at 50 MHz)
//  DEBOUNCE_CYCLES 1_000_000   consecutive stable cycles required to accept a key/switch change
//  REPEAT_DELAY    25_000_000  inc held this many cycles after its press pulse -> first repeat
//  REPEAT_PERIOD   5_000_000   cycles between subsequent inc repeat pulses while held
// PORTS
//  clk       in   1  system clock, single clock domain
//  rst_n     in   1  reset, asynchronous assert, active-low
//  key_stc_n in   1  raw unit-select key, active-low, asynchronous to clk
//  key_inc_n in   1  raw adjust key, active-low, asynchronous
//  key_run_n in   1  raw run/pause key, active-low, asynchronous
//  sw_dir    in   1  raw adjust-direction switch (1 = decrement), asynchronous
//  stc_p     out  1  one-cycle pulse: unit-select command
//  inc_p     out  1  one-cycle pulse: adjust command (press + auto-repeat)
//  run_p     out  1  one-cycle pulse: run/pause command
//  sw_s      out  1  debounced, synchronised sw_dir level
//  tick      out  1  one-cycle pulse every TICK_DIV cycles
//  blink     out  1  square wave, toggles on every tick
// BEHAVIOUR
//  - Reset: stc_p=inc_p=run_p=0, sw_s=0, tick=0, blink=0, prescaler=0, all keys "released",
//    all pending bits and repeat counters 0. Outputs registered; nothing combinational from inputs.
//  - Sync: every raw input through 2 flops. Debounce: per input, counter clears whenever the
//    synced value equals the accepted level; accepted level updates when counter reaches
//    DEBOUNCE_CYCLES-1 with synced != accepted. Glitches shorter than DEBOUNCE_CYCLES are ignored.
//  - Press event = accepted level released->pressed. Release generates nothing.
//  - Latency: raw key held low from cycle 0 -> pulse asserted at cycle DEBOUNCE_CYCLES+3, exactly 1 cycle.
//  - Auto-repeat (inc only): repeat counter starts at press event; while inc accepted-pressed,
//    event at REPEAT_DELAY, then every REPEAT_PERIOD. Release clears counter immediately.
//  - Arbiter: each key has a pending bit set by its event. Per cycle at most one of stc_p/inc_p/
//    run_p is high; priority stc > inc > run; emitted bit clears, others stay pending (never lost).
//    Event arriving on a key whose pending bit is still set is merged (one pulse).
//  - Prescaler: 0..TICK_DIV-1; tick=1 in the cycle after it wraps from TICK_DIV-1 to 0; blink toggles
//    on the same edge tick is asserted.
//  - run_p emission restarts prescaler at 0 (so the first tick after starting is a full period);
//    if wrap and run_p coincide, restart wins and that tick is suppressed; blink does not toggle.
//  - sw_s: debounced level only, no pulse; change visible DEBOUNCE_CYCLES+3 cycles after raw change.
//  - rst_n low mid-operation: all state to reset values asynchronously; pending pulses discarded;
//    a key held through reset release produces a press event only after a full debounce period.
// STRUCTURE
//  - Package timer_pkg: key index localparams KEY_STC=0, KEY_INC=1, KEY_RUN=2, NUM_KEYS=3;
//    default clock/tick constants; counter widths via $clog2 of the parameters.
//  - Sub-module input_debounce (2-flop sync + debounce counter + press-edge output), instanced
//    4x (3 keys, sw_dir). Repeat logic, arbiter, prescaler live in the top.
// TESTING  (bench params: TICK_DIV=10, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=6)
//  1. Reset release, no keys for 35 cycles -> tick at cycles 10,20,30; blink 0->1->0->1; no cmd pulses.
//  2. key_stc_n low at cycle 0 held 50 -> single stc_p at cycle 7; nothing on release.
//  3. key_run_n bounces 3-cycle lows x4 then low 10 -> no pulse from bounces, one run_p after stable run.
//  4. key_inc_n held 50 cycles -> inc_p at 7, 27, 33, 39, 45, 51 (press, +20, then every 6).
//  5. stc and run pressed same cycle -> stc_p at cycle N, run_p at N+1, never both high.
//  6. run_p emitted on prescaler wrap cycle -> no tick that period, next tick 10 cycles after run_p;
//     rst_n pulsed low with inc pending -> all outputs 0 immediately, no inc_p after release.

Source files
------------

// File: rtl/timer_input_conditioner_pkg.sv
// Shared constants for the timer front end: key indices, default timing, counter sizing.
package timer_pkg;

  localparam int KEY_STC  = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_RUN  = 2;
  localparam int NUM_KEYS = 3;

  localparam int unsigned DEF_TICK_DIV        = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/timer_input_conditioner_input_debounce.sv
// Two-flop synchroniser plus stability counter for one raw board input.
// Emits the accepted level, a one-cycle press event and a "still held" qualifier.
module input_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic        REST_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic active_o,
  output logic press_o,
  output logic held_o
);

  localparam int unsigned   CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign accept = (sync2_q != level_q) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = (sync2_q != REST_LEVEL);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= REST_LEVEL;
      sync2_q <= REST_LEVEL;
      level_q <= REST_LEVEL;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign active_o = (level_q != REST_LEVEL);
  assign press_o  = press_q;
  // Drops in the cycle a release is being accepted, so dependants never act on that edge.
  assign held_o   = active_o && !accept;

endmodule

// File: rtl/timer_input_conditioner.sv
// Countdown-timer front end: debounced key commands with inc auto-repeat, a fixed-priority
// single-pulse arbiter, the count-tick prescaler and the blink square wave.
module timer_input_conditioner
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_stc_n,
  input  logic key_inc_n,
  input  logic key_run_n,
  input  logic sw_dir,
  output logic stc_p,
  output logic inc_p,
  output logic run_p,
  output logic sw_s,
  output logic tick,
  output logic blink
);

  localparam int unsigned   PW          = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam int unsigned   RW          = cnt_w(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  key_vec_t key_raw, key_active, key_press, key_held;
  logic     sw_active, sw_press, sw_held;

  assign key_raw[KEY_STC] = key_stc_n;
  assign key_raw[KEY_INC] = key_inc_n;
  assign key_raw[KEY_RUN] = key_run_n;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REST_LEVEL     (1'b1)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (key_raw[g]),
      .active_o(key_active[g]),
      .press_o (key_press[g]),
      .held_o  (key_held[g])
    );
  end

  input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REST_LEVEL     (1'b0)
  ) u_db_sw (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (sw_dir),
    .active_o(sw_active),
    .press_o (sw_press),
    .held_o  (sw_held)
  );

  logic unused_flags;
  assign unused_flags = ^{key_active, key_held[KEY_STC], key_held[KEY_RUN], sw_press, sw_held};

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_armed_q, rep_armed_d;
  logic          rep_q, rep_d;
  logic [RW-1:0] rep_last;

  assign rep_last = rep_armed_q ? PERIOD_LAST : DELAY_LAST;

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_d       = 1'b0;
    if (!key_held[KEY_INC]) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (rep_cnt_q == rep_last) begin
      rep_d       = 1'b1;
      rep_cnt_d   = '0;
      rep_armed_d = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  key_vec_t key_evt, pend_q, pend_d, grant;

  assign key_evt[KEY_STC] = key_press[KEY_STC];
  assign key_evt[KEY_INC] = key_press[KEY_INC] | rep_q;
  assign key_evt[KEY_RUN] = key_press[KEY_RUN];

  always_comb begin
    grant = '0;
    if (pend_q[KEY_STC])      grant[KEY_STC] = 1'b1;
    else if (pend_q[KEY_INC]) grant[KEY_INC] = 1'b1;
    else if (pend_q[KEY_RUN]) grant[KEY_RUN] = 1'b1;
  end

  // Events on an already-pending key fold into the single outstanding pulse.
  assign pend_d = (pend_q & ~grant) | key_evt;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;

  // Starting a run restarts the period; a wrap in the same cycle is swallowed.
  always_comb begin
    presc_d = presc_q + 1'b1;
    tick_d  = 1'b0;
    blink_d = blink_q;
    if (grant[KEY_RUN]) begin
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
      blink_d = ~blink_q;
    end
  end

  logic stc_p_q, inc_p_q, run_p_q;
  logic sw_dly_q, sw_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      rep_q       <= 1'b0;
      pend_q      <= '0;
      stc_p_q     <= 1'b0;
      inc_p_q     <= 1'b0;
      run_p_q     <= 1'b0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      blink_q     <= 1'b0;
      sw_dly_q    <= 1'b0;
      sw_s_q      <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      rep_q       <= rep_d;
      pend_q      <= pend_d;
      stc_p_q     <= grant[KEY_STC];
      inc_p_q     <= grant[KEY_INC];
      run_p_q     <= grant[KEY_RUN];
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
      // Two stages keep sw_s in step with the press-to-pulse latency of the keys.
      sw_dly_q    <= sw_active;
      sw_s_q      <= sw_dly_q;
    end
  end

  assign stc_p = stc_p_q;
  assign inc_p = inc_p_q;
  assign run_p = run_p_q;
  assign sw_s  = sw_s_q;
  assign tick  = tick_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_timer_input_conditioner.sv
// Directed bench for timer_input_conditioner with short timing parameters.
module tb_timer_input_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_stc_n = 1'b1;
  logic key_inc_n = 1'b1;
  logic key_run_n = 1'b1;
  logic sw_dir = 1'b0;
  logic stc_p, inc_p, run_p, sw_s, tick, blink;
  logic [2:0] cmd;

  int n_checks = 0;
  int n_fail   = 0;

  assign cmd = {stc_p, inc_p, run_p};

  always #5 clk = ~clk;

  timer_input_conditioner #(
    .TICK_DIV       (10),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_stc_n(key_stc_n),
    .key_inc_n(key_inc_n),
    .key_run_n(key_run_n),
    .sw_dir   (sw_dir),
    .stc_p    (stc_p),
    .inc_p    (inc_p),
    .run_p    (run_p),
    .sw_s     (sw_s),
    .tick     (tick),
    .blink    (blink)
  );

  // Returns on a falling edge with reset just released: the next rising edge
  // is prescaler cycle 1 and key cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    key_stc_n = 1'b1;
    key_inc_n = 1'b1;
    key_run_n = 1'b1;
    sw_dir = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd, sw_s, tick, blink} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_state: outputs=%b expected 000000", {cmd, sw_s, tick, blink});
    end
  endtask

  task automatic test_prescaler();
    logic [1:0] exp_tb;
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      exp_tb = {(k % 10) == 0, ((k / 10) % 2) == 1};
      n_checks++;
      if ({tick, blink} !== exp_tb) begin
        n_fail++;
        $display("FAIL prescaler cycle %0d: tick,blink=%b expected %b", k, {tick, blink}, exp_tb);
      end
      n_checks++;
      if (cmd !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_cmd cycle %0d: cmd=%b expected 000", k, cmd);
      end
    end
  endtask

  task automatic test_stc_press();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k <= 64; k++) begin
      key_stc_n = (k < 50) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp = (k == 7) ? 3'b100 : 3'b000;
      n_checks++;
      if (cmd !== exp) begin
        n_fail++;
        $display("FAIL stc_press cycle %0d: cmd=%b expected %b", k, cmd, exp);
      end
    end
  endtask

  task automatic test_run_bounce();
    logic [2:0] exp;
    logic low;
    do_reset();
    for (int k = 0; k <= 49; k++) begin
      low = ((k < 24) && ((k % 6) < 3)) || ((k >= 24) && (k < 34));
      key_run_n = ~low;
      @(posedge clk); #1;
      exp = (k == 31) ? 3'b001 : 3'b000;
      n_checks++;
      if (cmd !== exp) begin
        n_fail++;
        $display("FAIL run_bounce cycle %0d: cmd=%b expected %b", k, cmd, exp);
      end
    end
  endtask

  task automatic test_inc_repeat();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k <= 70; k++) begin
      key_inc_n = (k < 50) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp = (k == 7 || k == 27 || k == 33 || k == 39 || k == 45 || k == 51) ? 3'b010 : 3'b000;
      n_checks++;
      if (cmd !== exp) begin
        n_fail++;
        $display("FAIL inc_repeat cycle %0d: cmd=%b expected %b", k, cmd, exp);
      end
    end
  endtask

  task automatic test_switch();
    logic exp;
    do_reset();
    for (int k = 0; k <= 35; k++) begin
      sw_dir = (k < 10) || ((k >= 13) && (k < 20));
      @(posedge clk); #1;
      exp = (k >= 7) && (k < 27);
      n_checks++;
      if (sw_s !== exp) begin
        n_fail++;
        $display("FAIL sw_level cycle %0d: sw_s=%b expected %b", k, sw_s, exp);
      end
      n_checks++;
      if (cmd !== 3'b000) begin
        n_fail++;
        $display("FAIL sw_no_cmd cycle %0d: cmd=%b expected 000", k, cmd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      key_stc_n = (k < 20) ? 1'b0 : 1'b1;
      key_run_n = (k < 20) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp = (k == 7) ? 3'b100 : (k == 8) ? 3'b001 : 3'b000;
      n_checks++;
      if (cmd !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: cmd=%b expected %b", k, cmd, exp);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [4:0] exp;
    // run_p lands on the wrap cycle (10): tick suppressed, next at 20 and 30
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      key_run_n = ((k >= 3) && (k < 20)) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp = {(k == 10) ? 3'b001 : 3'b000, (k == 20) || (k == 30), (k >= 20) && (k < 30)};
      n_checks++;
      if ({cmd, tick, blink} !== exp) begin
        n_fail++;
        $display("FAIL run_on_wrap cycle %0d: cmd,tick,blink=%b expected %b", k, {cmd, tick, blink}, exp);
      end
    end

    // inc becomes pending on prescaler cycle 10, then reset is pulsed
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      key_inc_n = (k >= 4) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      exp = {3'b000, k == 10, k == 10};
      n_checks++;
      if ({cmd, tick, blink} !== exp) begin
        n_fail++;
        $display("FAIL pre_reset cycle %0d: cmd,tick,blink=%b expected %b", k, {cmd, tick, blink}, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd, sw_s, tick, blink} !== 6'b000000) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%b expected 000000", {cmd, sw_s, tick, blink});
    end
    key_inc_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      exp = {3'b000, (k % 10) == 0, ((k / 10) % 2) == 1};
      n_checks++;
      if ({cmd, tick, blink} !== exp) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d: cmd,tick,blink=%b expected %b", k, {cmd, tick, blink}, exp);
      end
    end

    // inc held through reset release needs a full debounce before its press
    rst_n = 1'b0;
    key_inc_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
      exp = {(k == 7 || k == 27) ? 3'b010 : 3'b000, 2'b00};
      n_checks++;
      if ({cmd, 2'b00} !== exp) begin
        n_fail++;
        $display("FAIL held_through_reset cycle %0d: cmd=%b expected %b", k, cmd, exp[4:2]);
      end
    end
    key_inc_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_stc_press();
    test_run_bounce();
    test_inc_repeat();
    test_switch();
    test_back_to_back();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
